// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_inv accept side;
//        out_valid/out_ready/out_data result side. Column c = data[127-32c -: 32].
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $fatal(1, "mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int G = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST = 2'(G - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t       r_state;
    logic [1:0]   r_cnt;
    logic [127:0] r_in;
    logic         r_inv;
    logic [127:0] r_acc;
    logic [127:0] r_out;
    logic         r_valid;
    logic [127:0] w_next_acc;
    logic         w_accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse coefficients are composed from the x2/x4/x8 chain:
    // 09 = 8+1, 0B = 8+2+1, 0D = 8+4+1, 0E = 8+4+2.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            a[r]  = c[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        for (int r = 0; r < 4; r++) begin
            if (inv) begin
                res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                                 ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                                 ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                                 ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
            end else begin
                res[31-8*r -: 8] = x2[r]
                                 ^ (x2[(r+1)%4] ^ a[(r+1)%4])
                                 ^ a[(r+2)%4]
                                 ^ a[(r+3)%4];
            end
        end
        return res;
    endfunction

    // Transform the current column group on top of the partial result.
    always_comb begin
        w_next_acc = r_acc;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            int col;
            col = int'(r_cnt) * COLS_PER_CYCLE + j;
            w_next_acc[32*(3-col) +: 32] = mix_col(r_in[32*(3-col) +: 32], r_inv);
        end
    end

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_valid;
    assign out_data  = r_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_in    <= '0;
            r_inv   <= 1'b0;
            r_acc   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in    <= in_data;
                        r_inv   <= in_inv;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc <= w_next_acc;
                    r_cnt <= r_cnt + 2'd1;
                    // Only the complete result is published, on the final group.
                    if (r_cnt == LAST) begin
                        r_out   <= w_next_acc;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (in_valid) begin
                            r_in    <= in_data;
                            r_inv   <= in_inv;
                            r_cnt   <= '0;
                            r_state <= BUSY;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq; instances with COLS_PER_CYCLE = 1, 2, 4
// are compared against a generic GF(2^8) matrix-multiply reference model.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vin  [3];
    logic         rdy  [3];
    logic         inv  [3];
    logic         ov   [3];
    logic         ordy [3];
    logic [127:0] din  [3];
    logic [127:0] dout [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(1 << gi)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vin[gi]),
            .in_ready  (rdy[gi]),
            .in_data   (din[gi]),
            .in_inv    (inv[gi]),
            .out_valid (ov[gi]),
            .out_ready (ordy[gi]),
            .out_data  (dout[gi])
        );
    end

    // Generic GF(2^8) product, polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [8:0] x;
        p = 8'h00;
        x = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x[7:0];
            x = x << 1;
            if (x[8]) x = x ^ 9'h11b;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic m);
        logic [7:0]   fwd [4];
        logic [7:0]   bwd [4];
        logic [7:0]   col [4];
        logic [7:0]   acc;
        logic [127:0] res;
        fwd = '{8'h02, 8'h03, 8'h01, 8'h01};
        bwd = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) col[k] = d[127 - 32*c - 8*k -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(m ? bwd[(k - r + 4) % 4] : fwd[(k - r + 4) % 4], col[k]);
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic int grp(input int k);
        return 4 >> k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one block on an idle instance and count edges until out_valid.
    task automatic send(input int k, input logic [127:0] d, input logic m, output int n);
        vin[k] = 1'b1;
        din[k] = d;
        inv[k] = m;
        tick();
        vin[k] = 1'b0;
        n = 0;
        while (ov[k] !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
    endtask

    task automatic retire(input int k);
        ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_out_valid k=%0d got %b expected 0", k, ov[k]);
            end
            checks++;
            if (dout[k] !== 128'h0) begin
                failures++;
                $display("FAIL reset_out_data k=%0d got %h expected 0", k, dout[k]);
            end
            checks++;
            if (rdy[k] !== 1'b1) begin
                failures++;
                $display("FAIL reset_in_ready k=%0d got %b expected 1", k, rdy[k]);
            end
        end
    endtask

    task automatic test_vectors();
        logic [127:0] vd [5];
        logic         vm [5];
        logic [127:0] ve [5];
        int n;
        vd[0] = 128'hd4bf5d30e0b452aeb84111f11e2798e5; vm[0] = 1'b0;
        ve[0] = 128'h046681e5e0cb199a48f8d37a2806264c;
        vd[1] = 128'h046681e5e0cb199a48f8d37a2806264c; vm[1] = 1'b1;
        ve[1] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        vd[2] = 128'hdb135345f20a225c01010101c6c6c6c6; vm[2] = 1'b0;
        ve[2] = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
        vd[3] = 128'h8e4da1bc9fdc589d01010101c6c6c6c6; vm[3] = 1'b1;
        ve[3] = 128'hdb135345f20a225c01010101c6c6c6c6;
        vd[4] = 128'h01010101c6c6c6c6d4d4d4d52d26314c; vm[4] = 1'b0;
        ve[4] = 128'h01010101c6c6c6c6d5d5d7d64d7ebdf8;
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 5; v++) begin
                send(k, vd[v], vm[v], n);
                checks++;
                if (n != grp(k)) begin
                    failures++;
                    $display("FAIL vec_latency k=%0d v=%0d got %0d expected %0d", k, v, n, grp(k));
                end
                checks++;
                if (dout[k] !== ve[v]) begin
                    failures++;
                    $display("FAIL vec_data k=%0d v=%0d got %h expected %h", k, v, dout[k], ve[v]);
                end
                retire(k);
                checks++;
                if (ov[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL vec_retire k=%0d got %b expected 0", k, ov[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b, ea, eb;
        logic         ma, mb;
        int n;
        for (int k = 0; k < 3; k++) begin
            a  = {$urandom, $urandom, $urandom, $urandom};
            b  = {$urandom, $urandom, $urandom, $urandom};
            ma = 1'($urandom_range(0, 1));
            mb = 1'($urandom_range(0, 1));
            ea = model(a, ma);
            eb = model(b, mb);
            send(k, a, ma, n);
            checks++;
            if (n != grp(k)) begin
                failures++;
                $display("FAIL b2b_latency_a k=%0d got %0d expected %0d", k, n, grp(k));
            end
            for (int c = 0; c < 5; c++) begin
                vin[k]  = 1'b1;
                din[k]  = b;
                inv[k]  = ~mb;
                ordy[k] = 1'b0;
                tick();
                checks++;
                if (ov[k] !== 1'b1 || rdy[k] !== 1'b0 || dout[k] !== ea) begin
                    failures++;
                    $display("FAIL b2b_hold k=%0d c=%0d got v=%b r=%b d=%h expected v=1 r=0 d=%h",
                             k, c, ov[k], rdy[k], dout[k], ea);
                end
            end
            inv[k]  = mb;
            ordy[k] = 1'b1;
            #1;
            checks++;
            if (rdy[k] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready k=%0d got %b expected 1", k, rdy[k]);
            end
            tick();
            vin[k]  = 1'b0;
            ordy[k] = 1'b0;
            n = 0;
            while (ov[k] !== 1'b1 && n < 12) begin
                tick();
                n++;
            end
            checks++;
            if (n != grp(k)) begin
                failures++;
                $display("FAIL b2b_latency_b k=%0d got %0d expected %0d", k, n, grp(k));
            end
            checks++;
            if (dout[k] !== eb) begin
                failures++;
                $display("FAIL b2b_data_b k=%0d got %h expected %h", k, dout[k], eb);
            end
            retire(k);
        end
    endtask

    task automatic test_mode_latch();
        logic [127:0] d, e;
        int n;
        for (int m = 0; m < 2; m++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            e = model(d, 1'(m));
            vin[0] = 1'b1;
            din[0] = d;
            inv[0] = 1'(m);
            tick();
            vin[0] = 1'b0;
            n = 0;
            while (ov[0] !== 1'b1 && n < 12) begin
                inv[0] = ~inv[0];
                din[0] = {$urandom, $urandom, $urandom, $urandom};
                tick();
                n++;
            end
            checks++;
            if (dout[0] !== e || n != 4) begin
                failures++;
                $display("FAIL mode_latch m=%0d got %h n=%0d expected %h n=4", m, dout[0], n, e);
            end
            retire(0);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d;
        int n;
        d = {$urandom, $urandom, $urandom, $urandom};
        vin[0] = 1'b1;
        din[0] = d;
        inv[0] = 1'b0;
        tick();
        vin[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ov[0] !== 1'b0 || dout[0] !== 128'h0 || rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy got v=%b d=%h r=%b expected v=0 d=0 r=1", ov[0], dout[0], rdy[0]);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (ov[0] !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy_stale c=%0d got %b expected 0", c, ov[0]);
            end
        end
        d = {$urandom, $urandom, $urandom, $urandom};
        send(0, d, 1'b1, n);
        checks++;
        if (dout[0] !== model(d, 1'b1) || n != 4) begin
            failures++;
            $display("FAIL reset_after got %h n=%0d expected %h n=4", dout[0], n, model(d, 1'b1));
        end
        retire(0);
        send(1, d, 1'b0, n);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ov[1] !== 1'b0 || dout[1] !== 128'h0 || rdy[1] !== 1'b1) begin
            failures++;
            $display("FAIL reset_done got v=%b d=%h r=%b expected v=0 d=0 r=1", ov[1], dout[1], rdy[1]);
        end
    endtask

    task automatic test_random();
        logic [127:0] exp_q [$];
        logic [127:0] e;
        int acc, ret, cyc;
        for (int k = 0; k < 3; k++) begin
            exp_q.delete();
            acc = 0;
            ret = 0;
            cyc = 0;
            while ((acc < 1000 || exp_q.size() > 0) && cyc < 20000) begin
                vin[k]  = (acc < 1000) && ($urandom_range(0, 3) != 0);
                din[k]  = {$urandom, $urandom, $urandom, $urandom};
                inv[k]  = 1'($urandom_range(0, 1));
                ordy[k] = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (vin[k] && rdy[k]) begin
                    exp_q.push_back(model(din[k], inv[k]));
                    acc++;
                end
                if (ov[k] && ordy[k]) begin
                    ret++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL rand_dup k=%0d got %h expected no result", k, dout[k]);
                    end else begin
                        e = exp_q.pop_front();
                        if (dout[k] !== e) begin
                            failures++;
                            $display("FAIL rand_data k=%0d blk=%0d got %h expected %h", k, ret, dout[k], e);
                        end
                    end
                end
                tick();
                cyc++;
            end
            vin[k]  = 1'b0;
            ordy[k] = 1'b0;
            checks++;
            if (acc != 1000 || ret != 1000 || exp_q.size() != 0) begin
                failures++;
                $display("FAIL rand_count k=%0d got acc=%0d ret=%0d pend=%0d expected 1000/1000/0",
                         k, acc, ret, exp_q.size());
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            vin[k]  = 1'b0;
            inv[k]  = 1'b0;
            ordy[k] = 1'b0;
            din[k]  = '0;
        end
        test_reset();
        test_vectors();
        test_back_to_back();
        test_mode_latch();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
Sequential, parametrised AES MixColumns/InvMixColumns engine, the successor of the team's combinational MixColumns. It accepts one 128-bit state per valid/ready handshake and processes COLS_PER_CYCLE columns per clock, trading area for latency. A per-block mode bit selects the forward or the inverse transform, so one instance serves both the encrypt and decrypt round datapaths.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values are 1, 2 and 4; any other value is a fatal elaboration error.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input block valid
in_ready  output  1  engine can accept a block
in_data  input  128  AES state; column c = in_data[127-32c -: 32]; row 0 is the MSB byte of each column
in_inv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled at accept
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_data  output  128  transformed state, same byte layout as in_data

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and overrides all other inputs.
- Reset values: state=IDLE, out_valid=0, out_data=0, in_ready=1 in the cycle after reset deasserts, column counter=0.
- Define G = 4/COLS_PER_CYCLE, the number of column groups.
- Arithmetic is GF(2^8) with polynomial 0x11B.
  - xtime(a) = {a[6:0],0} ^ (a[7] ? 0x1B : 0).
  - Forward circulant matrix row: {02,03,01,01}.
  - Inverse circulant matrix row: {0E,0B,0D,09}, built from xtime chains.
  - Output byte r of column = XOR over k of M[(k-r) mod 4] * a_k.
- State machine has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register in_data and in_inv, clear the counter, and go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, transform columns [cnt*COLS_PER_CYCLE, +COLS_PER_CYCLE) and write them into the result register.
  - cnt increments. On cnt==G-1, go to DONE.
  - Accept-to-out_valid latency is exactly G cycles: out_valid rises G clock edges after the accept edge.
- DONE:
  - out_valid=1. out_data is held stable, and in_valid/in_inv are ignored, until out_ready=1.
  - in_ready = out_ready.
  - If out_ready=1 and in_valid=1 in the same cycle, the result retires and the new block is accepted on that edge; go directly to BUSY (back-to-back operation, no bubble cycle).
  - If out_ready=1 and in_valid=0, go to IDLE and clear out_valid.
- Sustained throughput is one block per G+1 cycles.
- out_data changes only on the BUSY-to-DONE edge. Partial results are never visible with out_valid=1.
- The mode latched at accept applies to all groups of that block. Toggling in_inv while BUSY has no effect.
- Reset mid-BUSY or mid-DONE discards the block. out_valid falls on the reset edge, and no stale result is ever presented afterwards.
- in_valid may be asserted in any state. It has effect only when in_ready=1.
- A block is always transformed as four independent columns; there is no cross-column interaction.

Test Plan:
- Forward FIPS-197 vector, COLS_PER_CYCLE=1,2,4: in_data=d4bf5d30e0b452aeb84111f11e2798e5, in_inv=0 -> out_data=046681e5e0cb199a48f8d37a2806264c, with out_valid exactly 4, 2 and 1 cycles after accept respectively.
- Inverse vector: in_data=046681e5e0cb199a48f8d37a2806264c, in_inv=1 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5. Also check single columns db135345 <-> 8e4da1bc and f20a225c <-> 9fdc589d.
- Fixed points: in_data=01010101c6c6c6c6d4d4d4d52d26314c, in_inv=0 -> 01010101c6c6c6c6d5d5d7d64d7ebdf8.
- Backpressure and back-to-back operation:
  - Hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0.
  - Then set out_ready=1 with in_valid=1 -> the next block is accepted on the same edge, and its result appears G cycles later.
  - Random valid/ready over 1000 blocks against a software model shows no loss or duplication.
- Mode latch: toggle in_inv every cycle while BUSY (COLS_PER_CYCLE=1) -> result matches the mode sampled at accept.
- Reset: assert rst in cycle 2 of BUSY -> next cycle out_valid=0, out_data=0, in_ready=1. A subsequent block produces a correct result.
